// File: rtl/ex_divider_pkg.sv
// Shared constants, FSM encoding and sign helpers for the execute-stage
// iterative divider.
package ex_divider_pkg;

  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIVIDE = 2'b01,
    ST_DONE   = 2'b10
  } div_state_e;

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return (is_signed && sv < 0) ? DATA_W'(-sv) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return neg ? DATA_W'(-sv) : v;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: stalls the pipeline for 32
// shift-subtract steps, then strobes quotient (LO) and remainder (HI) for one cycle.
module ex_divider
  import ex_divider_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              stall_request,
  output logic              done,
  output logic              register_hi_write_enable,
  output logic [DATA_W-1:0] register_hi_write_data,
  output logic              register_lo_write_enable,
  output logic [DATA_W-1:0] register_lo_write_data
);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     partial_q, partial_d;
  logic [DATA_W-1:0]       divisor_q, divisor_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;

  logic [DATA_W:0]         top;
  logic [DATA_W+1:0]       diff;
  logic [2*DATA_W-1:0]     step;
  logic                    in_done;

  // One shift-subtract step; the 33-bit window keeps the bit shifted out of
  // the remainder half so large divisors compare correctly.
  always_comb begin
    top  = partial_q[2*DATA_W-1:DATA_W-1];
    diff = {1'b0, top} - {2'b00, divisor_q};
    if (!diff[DATA_W+1]) begin
      step = {diff[DATA_W-1:0], partial_q[DATA_W-2:0], 1'b1};
    end else begin
      step = {top[DATA_W-1:0], partial_q[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (divisor == '0) begin
            // Divide by zero: LO all ones, HI the raw dividend.
            state_d   = ST_DONE;
            partial_d = {dividend, {DATA_W{1'b1}}};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            state_d   = ST_DIVIDE;
            cnt_d     = '0;
            partial_d = {{DATA_W{1'b0}}, magnitude(dividend, signed_div)};
            divisor_d = magnitude(divisor, signed_div);
            neg_quo_d = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_d = signed_div & dividend[DATA_W-1];
          end
        end
      end
      ST_DIVIDE: begin
        partial_d = step;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (cancel) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      partial_q <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // A flush arriving in DONE suppresses the strobe for the squashed instruction.
  assign in_done = (state_q == ST_DONE) && !cancel;

  assign stall_request = (state_q == ST_DIVIDE) ||
                         ((state_q == ST_IDLE) && start && !cancel);
  assign done                     = in_done;
  assign register_hi_write_enable = in_done ? WRITE_ENABLE : WRITE_DISABLE;
  assign register_lo_write_enable = in_done ? WRITE_ENABLE : WRITE_DISABLE;
  assign register_hi_write_data   = in_done ? cond_negate(partial_q[2*DATA_W-1:DATA_W], neg_rem_q)
                                            : '0;
  assign register_lo_write_data   = in_done ? cond_negate(partial_q[DATA_W-1:0], neg_quo_q)
                                            : '0;

endmodule
